// File: rtl/wb_wport_arbiter.sv
// Arbitrates the register-file write port between the pipeline writeback stage and a multi-cycle unit.
// Optional feature: define WPORT_BYPASS_EN to let an MCU result write straight through on an idle port.
module wb_wport_arbiter #(
   parameter int unsigned DEPTH      = 4,
   parameter int unsigned STARVE_MAX = 8
) (
   input  logic        cpu_clk_50M,
   input  logic        cpu_rst,
   input  logic        wb_wreg_i,
   input  logic [4:0]  wb_wa_i,
   input  logic [31:0] wb_wd_i,
   input  logic        mcu_valid_i,
   input  logic [4:0]  mcu_wa_i,
   input  logic [31:0] mcu_wd_i,
   output logic        mcu_ready_o,
   input  logic [4:0]  qry_addr_i,
   output logic        qry_hit_o,
   output logic        stall_o,
   output logic        rf_we_o,
   output logic [4:0]  rf_wa_o,
   output logic [31:0] rf_wd_o
);

   localparam int unsigned PTR_W = $clog2(DEPTH);
   localparam int unsigned CNT_W = PTR_W + 1;
   localparam int unsigned STV_W = 8;

   typedef struct packed {
      logic [4:0]  wa;
      logic [31:0] wd;
   } entry_t;

   entry_t             mem_q [DEPTH];
   logic [DEPTH-1:0]   vld_q, vld_d;
   logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
   logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic [STV_W-1:0]   starve_q, starve_d;

   logic   pipe_busy;
   logic   fifo_empty;
   logic   accept;
   logic   bypass;
   logic   push;
   logic   pop;
   entry_t head;

   assign head = mem_q[rd_ptr_q];

   // Handshake, starvation stall and write-port grant
   always_comb begin
      pipe_busy   = wb_wreg_i && (wb_wa_i != 5'd0);
      fifo_empty  = (cnt_q == '0);
      mcu_ready_o = !cpu_rst && (cnt_q < CNT_W'(DEPTH));
      accept      = mcu_valid_i && mcu_ready_o;
      stall_o     = !cpu_rst && (starve_q == STV_W'(STARVE_MAX));
      bypass      = 1'b0;
`ifdef WPORT_BYPASS_EN
      bypass      = accept && (mcu_wa_i != 5'd0) && fifo_empty && !pipe_busy && !stall_o;
`else
      bypass      = 1'b0;
`endif
      push        = accept && (mcu_wa_i != 5'd0) && !bypass;
      pop         = 1'b0;
      rf_we_o     = 1'b0;
      rf_wa_o     = 5'd0;
      rf_wd_o     = 32'd0;
      if (!cpu_rst) begin
         if (stall_o) begin
            rf_we_o = 1'b1;
            rf_wa_o = head.wa;
            rf_wd_o = head.wd;
            pop     = 1'b1;
         end else if (pipe_busy) begin
            rf_we_o = 1'b1;
            rf_wa_o = wb_wa_i;
            rf_wd_o = wb_wd_i;
         end else if (!fifo_empty) begin
            rf_we_o = 1'b1;
            rf_wa_o = head.wa;
            rf_wd_o = head.wd;
            pop     = 1'b1;
         end else if (bypass) begin
            rf_we_o = 1'b1;
            rf_wa_o = mcu_wa_i;
            rf_wd_o = mcu_wd_i;
         end
      end
   end

   // Pending-write lookup for the ID interlock; only already-queued entries count
   always_comb begin
      qry_hit_o = 1'b0;
      for (int i = 0; i < int'(DEPTH); i++) begin
         if (vld_q[i] && (mem_q[i].wa == qry_addr_i)) begin
            qry_hit_o = 1'b1;
         end
      end
      if (cpu_rst || (qry_addr_i == 5'd0)) begin
         qry_hit_o = 1'b0;
      end
   end

   always_comb begin
      rd_ptr_d = rd_ptr_q + PTR_W'(pop);
      wr_ptr_d = wr_ptr_q + PTR_W'(push);
      cnt_d    = cnt_q + CNT_W'(push) - CNT_W'(pop);
      vld_d    = vld_q;
      if (pop) begin
         vld_d[rd_ptr_q] = 1'b0;
      end
      if (push) begin
         vld_d[wr_ptr_q] = 1'b1;
      end
      starve_d = starve_q;
      if (pop || fifo_empty) begin
         starve_d = '0;
      end else if (pipe_busy && (starve_q != STV_W'(STARVE_MAX))) begin
         starve_d = starve_q + STV_W'(1);
      end
   end

   always_ff @(posedge cpu_clk_50M) begin
      if (cpu_rst) begin
         vld_q    <= '0;
         rd_ptr_q <= '0;
         wr_ptr_q <= '0;
         cnt_q    <= '0;
         starve_q <= '0;
      end else begin
         vld_q    <= vld_d;
         rd_ptr_q <= rd_ptr_d;
         wr_ptr_q <= wr_ptr_d;
         cnt_q    <= cnt_d;
         starve_q <= starve_d;
      end
   end

   // Payload storage needs no reset: validity is tracked in vld_q
   always_ff @(posedge cpu_clk_50M) begin
      if (push) begin
         mem_q[wr_ptr_q] <= '{wa: mcu_wa_i, wd: mcu_wd_i};
      end
   end

endmodule

// File: tb/tb_wb_wport_arbiter.sv
// Self-checking bench for wb_wport_arbiter: directed vector table, corner sequences, random vs. queue model.
module tb_wb_wport_arbiter;

   localparam int unsigned DEPTH      = 4;
   localparam int unsigned STARVE_MAX = 8;
`ifdef WPORT_BYPASS_EN
   localparam bit BYP = 1'b1;
`else
   localparam bit BYP = 1'b0;
`endif

   logic        clk;
   logic        rst;
   logic        wreg;
   logic [4:0]  wwa;
   logic [31:0] wwd;
   logic        mv;
   logic [4:0]  mwa;
   logic [31:0] mwd;
   logic [4:0]  qry;
   logic        mcu_ready_o, qry_hit_o, stall_o, rf_we_o;
   logic [4:0]  rf_wa_o;
   logic [31:0] rf_wd_o;
   logic [40:0] dout;

   int checks = 0;
   int errors = 0;

   wb_wport_arbiter #(.DEPTH(DEPTH), .STARVE_MAX(STARVE_MAX)) dut (
      .cpu_clk_50M (clk),
      .cpu_rst     (rst),
      .wb_wreg_i   (wreg),
      .wb_wa_i     (wwa),
      .wb_wd_i     (wwd),
      .mcu_valid_i (mv),
      .mcu_wa_i    (mwa),
      .mcu_wd_i    (mwd),
      .mcu_ready_o (mcu_ready_o),
      .qry_addr_i  (qry),
      .qry_hit_o   (qry_hit_o),
      .stall_o     (stall_o),
      .rf_we_o     (rf_we_o),
      .rf_wa_o     (rf_wa_o),
      .rf_wd_o     (rf_wd_o)
   );

   assign dout = {mcu_ready_o, qry_hit_o, stall_o, rf_we_o, rf_wa_o, rf_wd_o};

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // ---------------- reference model: queue of pending results ----------------
   typedef struct {
      logic [4:0]  wa;
      logic [31:0] wd;
   } ent_t;

   ent_t        mq[$];
   int          m_wait;
   logic [40:0] e_vec;
   bit          e_pop;

   function automatic logic [40:0] ov(bit r, bit h, bit s, bit we, logic [4:0] a, logic [31:0] d);
      return {r, h, s, we, a, d};
   endfunction

   function automatic void model_eval();
      bit ready, hit, stall, busy, acc, we;
      logic [4:0]  a;
      logic [31:0] d;
      ready = !rst && (mq.size() < DEPTH);
      stall = !rst && (m_wait == STARVE_MAX);
      busy  = wreg && (wwa != 0);
      acc   = mv && ready;
      hit   = 1'b0;
      if (!rst && qry != 0)
         foreach (mq[i]) if (mq[i].wa == qry) hit = 1'b1;
      we = 1'b0; a = '0; d = '0; e_pop = 1'b0;
      if (!rst) begin
         if (stall) begin
            we = 1'b1; a = mq[0].wa; d = mq[0].wd; e_pop = 1'b1;
         end else if (busy) begin
            we = 1'b1; a = wwa; d = wwd;
         end else if (mq.size() > 0) begin
            we = 1'b1; a = mq[0].wa; d = mq[0].wd; e_pop = 1'b1;
         end else if (BYP && acc && mwa != 0) begin
            we = 1'b1; a = mwa; d = mwd;
         end
      end
      e_vec = ov(ready, hit, stall, we, a, d);
   endfunction

   function automatic void model_update();
      bit acc, busy, was_empty, bypassed;
      model_eval();
      if (rst) begin
         mq.delete();
         m_wait = 0;
         return;
      end
      acc       = mv && (mq.size() < DEPTH);
      busy      = wreg && (wwa != 0);
      was_empty = (mq.size() == 0);
      bypassed  = BYP && was_empty && !busy && acc && mwa != 0;
      if (e_pop) void'(mq.pop_front());
      if (e_pop || was_empty) m_wait = 0;
      else if (busy && m_wait < STARVE_MAX) m_wait++;
      if (acc && mwa != 0 && !bypassed) mq.push_back('{wa: mwa, wd: mwd});
   endfunction

   // ---------------- helpers ----------------
   task automatic chk(string nm, logic [40:0] act, logic [40:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got rdy=%b hit=%b stall=%b we=%b wa=%0d wd=%h, expected rdy=%b hit=%b stall=%b we=%b wa=%0d wd=%h",
                  nm, act[40], act[39], act[38], act[37], act[36:32], act[31:0],
                  exp[40], exp[39], exp[38], exp[37], exp[36:32], exp[31:0]);
      end
   endtask

   task automatic drive(bit r, bit w, logic [4:0] wa, logic [31:0] wd,
                        bit v, logic [4:0] ma, logic [31:0] md, logic [4:0] q);
      rst = r; wreg = w; wwa = wa; wwd = wd; mv = v; mwa = ma; mwd = md; qry = q;
   endtask

   task automatic settle();
      @(negedge clk);
      model_eval();
   endtask

   task automatic tick();
      @(posedge clk);
      model_update();
      #1;
   endtask

   task automatic do_reset();
      drive(1, 0, 0, 0, 0, 0, 0, 0);
      settle();
      tick();
   endtask

   typedef struct {
      bit          r, w;
      logic [4:0]  wa;
      logic [31:0] wd;
      bit          v;
      logic [4:0]  ma;
      logic [31:0] md;
      logic [4:0]  q;
      logic [40:0] exp;
   } vec_t;

   function automatic vec_t mk(bit r, bit w, logic [4:0] wa, logic [31:0] wd, bit v,
                               logic [4:0] ma, logic [31:0] md, logic [4:0] q, logic [40:0] e);
      vec_t t;
      t.r = r; t.w = w; t.wa = wa; t.wd = wd; t.v = v; t.ma = ma; t.md = md; t.q = q; t.exp = e;
      return t;
   endfunction

   initial begin
      vec_t tbl[10];
      m_wait = 0;
      drive(1, 0, 0, 0, 0, 0, 0, 0);

      // reset with MCU valid, first idle cycle, single MCU result, $0 cases
      tbl[0] = mk(1, 0, 0, 0,     1, 5, 32'h1,        0, ov(0, 0, 0, 0, 0, 0));
      tbl[1] = mk(1, 0, 0, 0,     1, 5, 32'h1,        0, ov(0, 0, 0, 0, 0, 0));
      tbl[2] = mk(0, 0, 0, 0,     0, 0, 0,            5, ov(1, 0, 0, 0, 0, 0));
      tbl[3] = mk(0, 0, 0, 0,     1, 5, 32'hDEADBEEF, 5,
                  ov(1, 0, 0, BYP, BYP ? 5'd5 : 5'd0, BYP ? 32'hDEADBEEF : 32'h0));
      tbl[4] = mk(0, 0, 0, 0,     0, 0, 0,            5,
                  ov(1, !BYP, 0, !BYP, !BYP ? 5'd5 : 5'd0, !BYP ? 32'hDEADBEEF : 32'h0));
      tbl[5] = mk(0, 0, 0, 0,     0, 0, 0,            5, ov(1, 0, 0, 0, 0, 0));
      tbl[6] = mk(0, 0, 0, 0,     1, 0, 32'h1234,     0, ov(1, 0, 0, 0, 0, 0));
      tbl[7] = mk(0, 0, 0, 0,     0, 0, 0,            0, ov(1, 0, 0, 0, 0, 0));
      tbl[8] = mk(0, 1, 0, 32'h55, 0, 0, 0,           0, ov(1, 0, 0, 0, 0, 0));
      tbl[9] = mk(0, 1, 3, 32'hAAAA, 0, 0, 0,         0, ov(1, 0, 0, 1, 3, 32'hAAAA));

      for (int i = 0; i < 10; i++) begin
         drive(tbl[i].r, tbl[i].w, tbl[i].wa, tbl[i].wd, tbl[i].v, tbl[i].ma, tbl[i].md, tbl[i].q);
         settle();
         chk($sformatf("vec%0d", i), dout, tbl[i].exp);
         tick();
      end

      // FIFO fill under a busy pipeline: four accepted, fifth held, queued addresses hit
      do_reset();
      for (int k = 0; k < 5; k++) begin
         drive(0, 1, 3, 32'(k), 1, 5'(10 + k), 32'(100 + k), 0);
         settle();
         chk($sformatf("fill%0d", k), dout, ov(k < 4, 0, 0, 1, 3, 32'(k)));
         if (k == 4) begin
            for (int j = 0; j < 4; j++) begin
               qry = 5'(10 + j);
               #1;
               chk($sformatf("fill_hit%0d", j), dout, ov(0, 1, 0, 1, 3, 32'(k)));
            end
            qry = 5'd14;
            #1;
            chk("fill_nohit14", dout, ov(0, 0, 0, 1, 3, 32'(k)));
         end
         tick();
      end

      // starvation: one entry blocked by a pipeline writing every cycle
      do_reset();
      drive(0, 1, 3, 32'h3, 1, 7, 32'h77, 0);
      settle();
      tick();
      for (int d = 1; d <= 10; d++) begin
         drive(0, 1, 3, 32'h3, 0, 0, 0, 0);
         settle();
         chk($sformatf("starve_t+%0d", d), dout,
             (d == 9) ? ov(1, 0, 1, 1, 7, 32'h77) : ov(1, 0, 0, 1, 3, 32'h3));
         tick();
      end

      // reset mid-operation drops queued entries
      do_reset();
      for (int k = 0; k < 3; k++) begin
         drive(0, 1, 3, 32'h3, 1, 5'(20 + k), 32'(k), 0);
         settle();
         tick();
      end
      drive(1, 0, 0, 0, 0, 0, 0, 20);
      settle();
      chk("midrst_during", dout, ov(0, 0, 0, 0, 0, 0));
      tick();
      for (int k = 0; k < 3; k++) begin
         drive(0, 0, 0, 0, 0, 0, 0, 5'(20 + k));
         settle();
         chk($sformatf("midrst_after%0d", k), dout, ov(1, 0, 0, 0, 0, 0));
         tick();
      end

      // randomized traffic against the queue model
      for (int i = 0; i < 3000; i++) begin
         int pbusy;
         pbusy = ((i / 300) % 3 == 0) ? 90 : (((i / 300) % 3 == 1) ? 50 : 10);
         drive(($urandom % 200) == 0, ($urandom % 100) < pbusy, 5'($urandom % 4), $urandom,
               $urandom % 2, 5'($urandom % 8), $urandom, 5'($urandom % 8));
         settle();
         chk($sformatf("rand%0d", i), dout, e_vec);
         tick();
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
